// File: rtl/magia_l2_obi_arbiter.sv
// Round-robin arbiter sharing one OBI L2 port among NumReq requesters, with an
// in-order ID FIFO that steers memory responses back to the issuing requester.
module magia_l2_obi_arbiter #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumReq-1:0]                   req_i,
  input  logic [NumReq*AddrWidth-1:0]         addr_i,
  input  logic [NumReq-1:0]                   we_i,
  input  logic [NumReq*DataWidth/8-1:0]       be_i,
  input  logic [NumReq*DataWidth-1:0]         wdata_i,
  output logic [NumReq-1:0]                   gnt_o,
  output logic [NumReq-1:0]                   rvalid_o,
  output logic [DataWidth-1:0]                rdata_o,
  output logic                                mem_req_o,
  output logic [AddrWidth-1:0]                mem_addr_o,
  output logic                                mem_we_o,
  output logic [DataWidth/8-1:0]              mem_be_o,
  output logic [DataWidth-1:0]                mem_wdata_o,
  input  logic                                mem_gnt_i,
  input  logic                                mem_rvalid_i,
  input  logic [DataWidth-1:0]                mem_rdata_i,
  output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
  output logic                                err_o
);

  localparam int unsigned IdW  = $clog2(NumReq);
  localparam int unsigned BeW  = DataWidth / 8;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [IdW:0] NUM_REQ = (IdW + 1)'(NumReq);

  logic [IdW-1:0]  rr_ptr, locked_id, winner, head;
  logic            lock, err;
  logic [IdW-1:0]  id_fifo [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic [CntW-1:0] count;
  logic            full, mem_req, handshake, pop, found;
  logic [IdW:0]    idx;
  logic [AddrWidth-1:0] sel_addr;
  logic [BeW-1:0]       sel_be;
  logic [DataWidth-1:0] sel_wdata;
  logic                 sel_we;

  function automatic logic [IdW-1:0] next_id(input logic [IdW-1:0] id);
    return (id == IdW'(NumReq - 1)) ? '0 : id + IdW'(1);
  endfunction

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Round-robin search from rr_ptr; a pending ungranted request pins the winner.
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NumReq; i++) begin
      idx = {1'b0, rr_ptr} + (IdW + 1)'(i);
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_i[idx[IdW-1:0]]) begin
        winner = idx[IdW-1:0];
        found  = 1'b1;
      end
    end
    if (lock) winner = locked_id;
  end

  always_comb begin
    sel_addr  = '0;
    sel_be    = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (winner == IdW'(i)) begin
        sel_addr  = addr_i[i*AddrWidth +: AddrWidth];
        sel_be    = be_i[i*BeW +: BeW];
        sel_wdata = wdata_i[i*DataWidth +: DataWidth];
        sel_we    = we_i[i];
      end
    end
  end

  assign full      = (count == CntW'(MaxOutstanding));
  assign mem_req   = (|req_i) & ~full & ~rst_i;
  assign handshake = mem_req & mem_gnt_i;
  assign pop       = mem_rvalid_i & (count != '0) & ~rst_i;
  assign head      = id_fifo[rd_ptr];

  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      gnt_o[i]    = handshake & (winner == IdW'(i));
      rvalid_o[i] = pop & (head == IdW'(i));
    end
  end

  assign rdata_o       = pop ? mem_rdata_i : '0;
  assign mem_req_o     = mem_req;
  assign mem_addr_o    = rst_i ? '0 : sel_addr;
  assign mem_we_o      = ~rst_i & sel_we;
  assign mem_be_o      = rst_i ? '0 : sel_be;
  assign mem_wdata_o   = rst_i ? '0 : sel_wdata;
  assign outstanding_o = rst_i ? '0 : count;
  assign err_o         = ~rst_i & err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
      lock   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (handshake) begin
        rr_ptr <= next_id(winner);
        lock   <= 1'b0;
        wr_ptr <= next_ptr(wr_ptr);
      end else if (mem_req) begin
        lock <= 1'b1;
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      if (handshake && !pop)      count <= count + CntW'(1);
      else if (!handshake && pop) count <= count - CntW'(1);
      if (mem_rvalid_i && count == '0) err <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_req && !mem_gnt_i) locked_id <= winner;
    if (handshake) id_fifo[wr_ptr] <= winner;
  end

endmodule

// File: tb/tb_magia_l2_obi_arbiter.sv
// Directed-vector bench for magia_l2_obi_arbiter: inputs change on the falling
// edge and outputs are compared 1 ns later, well away from the rising edge.
module tb_magia_l2_obi_arbiter;
  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req, we;
  logic [NR*AW-1:0]  addr;
  logic [NR*DW/8-1:0] be;
  logic [NR*DW-1:0]  wdata;
  logic [NR-1:0]     gnt, rvalid;
  logic [DW-1:0]     rdata;
  logic              mem_req, mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW/8-1:0]   mem_be;
  logic [DW-1:0]     mem_wdata;
  logic              mem_gnt, mem_rvalid;
  logic [DW-1:0]     mem_rdata;
  logic [$clog2(MO+1)-1:0] outstanding;
  logic              err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  magia_l2_obi_arbiter #(
    .NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .outstanding_o(outstanding), .err_o(err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    cyc(); rst = 1'b1; idle_inputs();
    cyc(); rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; we = '0; be = '0; wdata = '0; addr = '0; idle_inputs();
    // Outputs forced low during reset even with live inputs
    cyc(); req = 4'b0001; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234; #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_outst", outstanding, 0);
    chk("rst_err", err, 0);
    cyc(); rst = 1'b0; idle_inputs();

    // Single requester read
    cyc(); req = 4'b0001; addr[0*AW +: AW] = 32'h1C00_0000; mem_gnt = 1'b1; #1;
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_mem_req", mem_req, 1);
    chk("t1_addr", mem_addr, 32'h1C00_0000);
    chk("t1_we", mem_we, 0);
    cyc(); idle_inputs(); #1;
    chk("t1_outst", outstanding, 1);
    cyc(); mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
    chk("t1_rvalid", rvalid, 4'b0001);
    chk("t1_rdata", rdata, 32'hDEAD_BEEF);
    cyc(); idle_inputs(); #1;
    chk("t1_outst_end", outstanding, 0);
    chk("t1_rdata_idle", rdata, 0);

    // Round robin with all four requesting
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cyc(); req = 4'b1111; mem_gnt = 1'b1; mem_rvalid = (k > 0); mem_rdata = k * 32'h11; #1;
      chk("t2_gnt", gnt, 1 << (k % 4));
      chk("t2_outst", outstanding, (k > 0) ? 1 : 0);
      if (k > 0) begin
        chk("t2_rvalid", rvalid, 1 << ((k - 1) % 4));
        chk("t2_rdata", rdata, k * 32'h11);
      end
    end
    cyc(); idle_inputs(); mem_rvalid = 1'b1; mem_rdata = 32'h66; #1;
    chk("t2_rvalid_last", rvalid, 4'b0010);
    cyc(); idle_inputs(); #1;
    chk("t2_outst_end", outstanding, 0);

    // Lock holds the winner while ungranted
    do_reset();
    addr[0*AW +: AW] = 32'hA000_0000; addr[1*AW +: AW] = 32'hA111_1111;
    for (int k = 0; k < 3; k++) begin
      cyc(); req = 4'b0011; mem_gnt = 1'b0; #1;
      chk("t3_wait_gnt", gnt, 0);
      chk("t3_wait_req", mem_req, 1);
      chk("t3_wait_addr", mem_addr, 32'hA000_0000);
    end
    cyc(); mem_gnt = 1'b1; #1;
    chk("t3_gnt", gnt, 4'b0001);
    cyc(); req = 4'b0001; mem_gnt = 1'b0; #1;
    chk("t3_lock0_addr", mem_addr, 32'hA000_0000);
    cyc(); req = 4'b0011; #1;
    chk("t3_lock_hold_addr", mem_addr, 32'hA000_0000);
    chk("t3_lock_hold_gnt", gnt, 0);
    cyc(); mem_gnt = 1'b1; #1;
    chk("t3_lock_gnt", gnt, 4'b0001);
    cyc(); idle_inputs(); mem_rvalid = 1'b1; #1;
    chk("t3_rv0", rvalid, 4'b0001);
    cyc(); #1;
    chk("t3_rv1", rvalid, 4'b0001);
    cyc(); idle_inputs(); #1;
    chk("t3_outst_end", outstanding, 0);

    // FIFO full blocks requests, even alongside a response
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cyc(); req = 4'b0001; mem_gnt = 1'b1; #1;
      chk("t4_fill_gnt", gnt, 4'b0001);
      chk("t4_fill_outst", outstanding, k);
    end
    cyc(); mem_rvalid = 1'b1; #1;
    chk("t4_full_outst", outstanding, 4);
    chk("t4_full_req", mem_req, 0);
    chk("t4_full_gnt", gnt, 0);
    chk("t4_full_rvalid", rvalid, 4'b0001);
    cyc(); mem_rvalid = 1'b0; #1;
    chk("t4_free_outst", outstanding, 3);
    chk("t4_free_req", mem_req, 1);
    chk("t4_free_gnt", gnt, 4'b0001);
    cyc(); idle_inputs(); #1;
    chk("t4_refull", outstanding, 4);
    for (int k = 0; k < 4; k++) begin
      cyc(); mem_rvalid = 1'b1; #1;
      chk("t4_drain", rvalid, 4'b0001);
    end
    cyc(); idle_inputs(); #1;
    chk("t4_outst_end", outstanding, 0);

    // Response ordering, write path and push+pop
    do_reset();
    addr[2*AW +: AW] = 32'h2000_0020; we = 4'b0100; be[2*4 +: 4] = 4'b0110;
    wdata[2*DW +: DW] = 32'hCAFE_F00D;
    cyc(); req = 4'b0100; mem_gnt = 1'b1; #1;
    chk("t5_gnt2", gnt, 4'b0100);
    chk("t5_we", mem_we, 1);
    chk("t5_be", mem_be, 4'b0110);
    chk("t5_wdata", mem_wdata, 32'hCAFE_F00D);
    chk("t5_addr", mem_addr, 32'h2000_0020);
    cyc(); req = 4'b0001; #1;
    chk("t5_gnt0", gnt, 4'b0001);
    chk("t5_we0", mem_we, 0);
    cyc(); req = 4'b1000; mem_rvalid = 1'b1; mem_rdata = 32'hD0D0_D0D0; #1;
    chk("t5_gnt3", gnt, 4'b1000);
    chk("t5_rv_d0", rvalid, 4'b0100);
    chk("t5_rd_d0", rdata, 32'hD0D0_D0D0);
    chk("t5_outst_pp", outstanding, 2);
    cyc(); req = '0; mem_gnt = 1'b0; mem_rdata = 32'hD1D1_D1D1; #1;
    chk("t5_outst_kept", outstanding, 2);
    chk("t5_rv_d1", rvalid, 4'b0001);
    chk("t5_rd_d1", rdata, 32'hD1D1_D1D1);
    cyc(); mem_rdata = 32'hD2D2_D2D2; #1;
    chk("t5_rv_d2", rvalid, 4'b1000);
    chk("t5_rd_d2", rdata, 32'hD2D2_D2D2);
    chk("t5_outst_1", outstanding, 1);
    cyc(); idle_inputs(); we = '0; #1;
    chk("t5_outst_end", outstanding, 0);

    // Stray response sets sticky error; reset clears state
    cyc(); mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0; #1;
    chk("t6_stray_rv", rvalid, 0);
    chk("t6_stray_rdata", rdata, 0);
    chk("t6_err_pre", err, 0);
    cyc(); idle_inputs(); #1;
    chk("t6_err_set", err, 1);
    chk("t6_outst", outstanding, 0);
    cyc(); #1;
    chk("t6_err_sticky", err, 1);
    cyc(); req = 4'b0011; mem_gnt = 1'b1; #1;
    chk("t6_gnt_a", gnt, 4'b0001);
    cyc(); #1;
    chk("t6_gnt_b", gnt, 4'b0010);
    cyc(); rst = 1'b1; req = 4'b1111; #1;
    chk("t6_rst_req", mem_req, 0);
    chk("t6_rst_gnt", gnt, 0);
    cyc(); rst = 1'b0; idle_inputs(); #1;
    chk("t6_post_outst", outstanding, 0);
    chk("t6_post_err", err, 0);
    cyc(); mem_rvalid = 1'b1; #1;
    chk("t6_late_rv", rvalid, 0);
    cyc(); idle_inputs(); req = 4'b1111; mem_gnt = 1'b1; #1;
    chk("t6_late_err", err, 1);
    chk("t6_ptr_reset", gnt, 4'b0001);
    cyc(); idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
